bcd_gate_cntr_ctrl: RTL and testbench

BCD_GATE_CNTR_CTRL -- requirements
Module: bcd_gate_cntr_ctrl

---
 rtl/bcd_cntr_pkg.sv | 34 +++
 rtl/bcd_digit.sv | 27 ++
 rtl/bcd_gate_cntr_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bcd_gate_cntr_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_cntr_pkg.sv
// Shared definitions for the gated BCD event counter: FSM state encoding,
// BCD digit constants and the single-digit increment rule.
package bcd_cntr_pkg;

    // Measurement controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GATE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Width of one packed BCD digit
    localparam int BCD_W = 4;

    // Largest value a BCD digit can hold before it wraps
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Value a digit takes after this clock when its increment enable is inc
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q,
                                                  input logic             inc);
        logic [BCD_W-1:0] nxt;
        nxt = q;
        if (inc) begin
            if (q == BCD_MAX) begin
                nxt = '0;
            end else begin
                nxt = q + 4'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the synchronous BCD counter. All digits share clk; the carry
// between decades is an enable (inc) computed by the parent, never a clock.
module bcd_digit
    import bcd_cntr_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             is_nine
);

    // Digit register: synchronous clear wins over increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= bcd_next(q, inc);
        end
    end

    assign is_nine = (q == BCD_MAX);

endmodule

// File: rtl/bcd_gate_cntr_ctrl.sv
// Gated BCD event counter. A start in IDLE clears the count, opens a gate of
// GATE_CYCLES clocks during which each synchronized rising edge of evt adds
// one to a DIGITS-wide BCD counter, then presents the result (and an
// overflow flag) with res_valid until res_ready accepts it.
//
// Result handshake: res_valid is high for every HOLD cycle; res_bcd/res_ovf
// are stable while res_valid=1 and res_ready=0; the result is consumed on the
// clock edge where res_valid and res_ready are both 1, and res_valid is low
// on the following cycle. abort drops a pending result without consuming it.
module bcd_gate_cntr_ctrl
    import bcd_cntr_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int GATE_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    evt,
    output logic [BCD_W*DIGITS-1:0] res_bcd,
    output logic                    res_ovf,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = BCD_W * DIGITS;
    localparam int GCW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GCW-1:0] GATE_LAST = GCW'(GATE_CYCLES - 1);

    state_t            state;
    logic              evt_s1;
    logic              evt_s2;
    logic              evt_s3;
    logic [1:0]        prime;
    logic              evt_rise;
    logic [GCW-1:0]    gate_cnt;
    logic              gate_last;
    logic              clr_cnt;
    logic              count_en;
    logic              ovf_flag;
    logic              ovf_next;
    logic              all_nine;
    logic [DIGITS-1:0] nine;
    logic [DIGITS-1:0] inc;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_next;

    assign dbg_state = state;

    // Two-flop synchronizer plus edge history. prime counts the first three
    // clocks after reset so that the reset value of the history flops can
    // never masquerade as a rising edge (an evt already high at release).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_s1 <= 1'b0;
            evt_s2 <= 1'b0;
            evt_s3 <= 1'b0;
            prime  <= 2'd0;
        end else begin
            evt_s1 <= evt;
            evt_s2 <= evt_s1;
            evt_s3 <= evt_s2;
            if (prime != 2'd3) begin
                prime <= prime + 2'd1;
            end
        end
    end

    assign evt_rise  = evt_s2 & ~evt_s3 & (prime == 2'd3);
    assign clr_cnt   = (state == ST_CLEAR);
    assign count_en  = (state == ST_GATE) & evt_rise;
    assign gate_last = (state == ST_GATE) && (gate_cnt == GATE_LAST);
    assign all_nine  = &nine;
    assign ovf_next  = ovf_flag | (count_en & all_nine);

    // Carry chain: a digit advances when every lower digit is 9
    always_comb begin
        logic carry;
        carry = count_en;
        inc   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            inc[i] = carry;
            carry  = carry & nine[i];
        end
    end

    // Decades of the counter, plus their next value for the result register
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .rstn    (rstn),
            .clr     (clr_cnt),
            .inc     (inc[g]),
            .q       (cnt_q[g*BCD_W +: BCD_W]),
            .is_nine (nine[g])
        );
        assign cnt_next[g*BCD_W +: BCD_W] = bcd_next(cnt_q[g*BCD_W +: BCD_W], inc[g]);
    end

    // Gate timer: zeroed in CLEAR, advances once per GATE cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gate_cnt <= '0;
        end else if (clr_cnt) begin
            gate_cnt <= '0;
        end else if (state == ST_GATE) begin
            gate_cnt <= gate_cnt + GCW'(1);
        end
    end

    // Sticky overflow: set when a full counter rolls over, cleared in CLEAR
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_flag <= 1'b0;
        end else if (clr_cnt) begin
            ovf_flag <= 1'b0;
        end else if (count_en && all_nine) begin
            ovf_flag <= 1'b1;
        end
    end

    // Measurement FSM with registered busy/result outputs. The result is
    // captured from the next-count value so an edge in the last GATE cycle
    // is included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_bcd   <= '0;
            res_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (gate_last) begin
                        state     <= ST_HOLD;
                        res_valid <= 1'b1;
                        res_bcd   <= cnt_next;
                        res_ovf   <= ovf_next;
                    end
                end
                ST_HOLD: begin
                    if (abort || res_ready) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_gate_cntr_ctrl.sv
// Bench for the gated BCD event counter. Inputs change 2 time units after a
// rising clock edge; the result monitors sample on the falling edge. The
// reference model counts rising edges of the logged evt waveform that fall
// inside the gate window, allowing for the synchronizer delay.
module tb_bcd_gate_cntr_ctrl;

    localparam int DIGITS = 4;
    localparam int GATE   = 10;
    localparam int LONG_G = 20002;
    localparam int W      = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn        = 1'b0;
    logic        start       = 1'b0;
    logic        start_l     = 1'b0;
    logic        abort       = 1'b0;
    logic        evt         = 1'b0;
    logic        res_ready   = 1'b0;
    logic        res_ready_l = 1'b0;
    logic [15:0] res_bcd;
    logic [15:0] res_bcd_l;
    logic        res_ovf;
    logic        res_ovf_l;
    logic        res_valid;
    logic        res_valid_l;
    logic        busy;
    logic        busy_l;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_state_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid = 32'h3fff_ffff;
    bit evt_log [0:65535];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_l_q[$];
    logic [W-1:0] last_res = '0;

    bcd_gate_cntr_ctrl #(.DIGITS(DIGITS), .GATE_CYCLES(GATE)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .evt(evt),
        .res_bcd(res_bcd), .res_ovf(res_ovf), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .dbg_state(dbg_state)
    );

    bcd_gate_cntr_ctrl #(.DIGITS(DIGITS), .GATE_CYCLES(LONG_G)) dut_long (
        .clk(clk), .rstn(rstn), .start(start_l), .abort(abort), .evt(evt),
        .res_bcd(res_bcd_l), .res_ovf(res_ovf_l), .res_valid(res_valid_l),
        .res_ready(res_ready_l), .busy(busy_l), .dbg_state(dbg_state_l)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Log the evt value that the next rising edge will sample, then advance
    task automatic tick();
        evt_log[cyc+1] = evt;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return b;
    endfunction

    // Reference: start sampled at edge p; edges p+2 .. p+1+g are gate edges.
    // A rise sampled at edge k is counted at edge k+2; samples taken before
    // reset release never form an edge.
    function automatic logic [W-1:0] model_result(input int p, input int g);
        int n;
        n = 0;
        for (int m = p + 2; m <= p + 1 + g; m++) begin
            if ((m - 3 >= first_valid) && evt_log[m-2] && !evt_log[m-3]) n++;
        end
        return {(n >= 10000), to_bcd(n % 10000)};
    endfunction

    // evt waveform generators, rel = edge index relative to the start edge
    function automatic logic evt_pat(input int mode, input int p, input int rel);
        case (mode)
            0:       return 1'($urandom_range(0, 1));
            1:       return (rel == GATE - 1);
            2:       return (rel == GATE);
            3:       return 1'b1;
            4:       return (rel != 2);
            5:       return (rel < 21) && (rel % 3 == 0);
            6:       return 1'((p + rel) % 2);
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic measure_main(input int mode, input int hold_lo, input bit start_in_hold,
                                input bit early_ready);
        int p;
        int r;
        logic [W-1:0] e;
        p = cyc + 1;
        start = 1'b1;
        res_ready = early_ready;
        evt = evt_pat(mode, p, 0);
        tick();
        start = 1'b0;
        for (r = 1; r <= GATE + 1; r++) begin
            evt = evt_pat(mode, p, r);
            tick();
        end
        e = model_result(p, GATE);
        exp_q.push_back(e);
        last_res = e;
        check("valid_at_hold", res_valid, 1);
        for (int w = 0; w < 20 && !res_valid; w++) begin
            evt = evt_pat(mode, p, r);
            r++;
            tick();
        end
        for (int h = 0; h < hold_lo; h++) begin
            res_ready = 1'b0;
            start = start_in_hold && (h % 2 == 0);
            evt = evt_pat(mode, p, r);
            r++;
            tick();
            check("hold_busy", busy, 1);
            check("hold_valid", res_valid, 1);
            check("hold_result", {res_ovf, res_bcd}, e);
        end
        start = 1'b0;
        res_ready = 1'b1;
        evt = evt_pat(mode, p, r);
        tick();
        res_ready = 1'b0;
        check("after_accept_valid", res_valid, 0);
        check("after_accept_busy", busy, 0);
        check("after_accept_state", dbg_state, 0);
        tick();
        check("idle_busy", busy, 0);
    endtask

    task automatic measure_long(input int mode);
        int p;
        logic [W-1:0] e;
        p = cyc + 1;
        start_l = 1'b1;
        evt = evt_pat(mode, p, 0);
        tick();
        start_l = 1'b0;
        for (int r = 1; r <= LONG_G + 1; r++) begin
            evt = evt_pat(mode, p, r);
            tick();
        end
        e = model_result(p, LONG_G);
        exp_l_q.push_back(e);
        check("long_valid_at_hold", res_valid_l, 1);
        res_ready_l = 1'b1;
        evt = 1'b0;
        tick();
        res_ready_l = 1'b0;
        check("long_after_accept_valid", res_valid_l, 0);
        check("long_after_accept_busy", busy_l, 0);
        check("long_after_accept_state", dbg_state_l, 0);
    endtask

    task automatic abort_in_gate();
        int p;
        p = cyc + 1;
        start = 1'b1;
        evt = evt_pat(0, p, 0);
        tick();
        start = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            evt = evt_pat(0, p, r);
            tick();
        end
        check("gate_busy_before_abort", busy, 1);
        abort = 1'b1;
        evt = evt_pat(0, p, 6);
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        check("abort_keeps_bcd", res_bcd, last_res[15:0]);
        for (int i = 0; i < 15; i++) begin
            evt = evt_pat(0, p, 7 + i);
            tick();
            check("abort_no_valid", res_valid, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bcd"}, res_bcd, 0);
        check({tag, "_ovf"}, res_ovf, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state"}, dbg_state, 0);
        check({tag, "_long_busy"}, busy_l, 0);
        check({tag, "_long_valid"}, res_valid_l, 0);
    endtask

    // ---------------- scoreboard monitors ----------------
    logic [W-1:0] held;
    bit           held_v = 1'b0;
    always @(negedge clk) begin : mon_main
        logic [W-1:0] e;
        if (rstn && res_valid && held_v) begin
            checks++;
            if ({res_ovf, res_bcd} !== held) begin
                errors++;
                $display("FAIL hold_stable actual=%0h required=%0h", {res_ovf, res_bcd}, held);
            end
        end
        if (rstn && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected actual=%0h required=none", {res_ovf, res_bcd});
            end else begin
                e = exp_q.pop_front();
                if ({res_ovf, res_bcd} !== e) begin
                    errors++;
                    $display("FAIL result actual=%0h required=%0h", {res_ovf, res_bcd}, e);
                end
            end
        end
        held_v = rstn && res_valid && !res_ready;
        held   = {res_ovf, res_bcd};
    end

    always @(negedge clk) begin : mon_long
        logic [W-1:0] e;
        if (rstn && res_valid_l && res_ready_l) begin
            checks++;
            if (exp_l_q.size() == 0) begin
                errors++;
                $display("FAIL long_result_unexpected actual=%0h required=none", {res_ovf_l, res_bcd_l});
            end else begin
                e = exp_l_q.pop_front();
                if ({res_ovf_l, res_bcd_l} !== e) begin
                    errors++;
                    $display("FAIL long_result actual=%0h required=%0h", {res_ovf_l, res_bcd_l}, e);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        tick();
        tick();
        tick();
        check_all_zero("reset");

        rstn = 1'b1;
        first_valid = cyc + 1;
        for (int i = 0; i < 4; i++) tick();
        check_all_zero("post_reset");

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        tick();
        check("start_abort_state", dbg_state, 0);

        // edge in the last gate cycle counts, edge in first HOLD cycle does not
        measure_main(1, 0, 1'b0, 1'b0);
        measure_main(2, 0, 1'b0, 1'b0);

        // long hold with ignored start pulses
        measure_main(0, 20, 1'b1, 1'b0);

        // abort in the fifth gate cycle
        abort_in_gate();

        // randomized measurements, ready sometimes waiting from the start
        for (int i = 0; i < 8; i++) begin
            int hl;
            hl = $urandom_range(0, 3);
            measure_main(0, hl, 1'b0, (hl == 0) && ($urandom_range(0, 1) == 1));
        end

        // reset pulse during GATE with evt held high across the release
        begin
            start = 1'b1;
            evt = 1'b1;
            tick();
            start = 1'b0;
            for (int r = 1; r <= 4; r++) tick();
            check("pre_reset_busy", busy, 1);
            rstn = 1'b0;
            #1;
            check_all_zero("async_reset");
            tick();
            tick();
            check_all_zero("in_reset");
            last_res = '0;
            rstn = 1'b1;
            first_valid = cyc + 1;
            measure_main(3, 1, 1'b0, 1'b0);
            measure_main(4, 0, 1'b0, 1'b0);
        end

        // long gate: seven pulses, then rollover past 9999
        evt = 1'b0;
        tick();
        tick();
        measure_long(5);
        evt = 1'b0;
        tick();
        measure_long(6);

        for (int i = 0; i < 4; i++) tick();
        check("queue_empty", exp_q.size(), 0);
        check("long_queue_empty", exp_l_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
